frame_pixel_server: RTL and testbench

//  Frame-buffer responder for the FAST corner pipeline's pixel read interface.

---
 rtl/frame_pixel_server.sv | 169 ++++++++++++++++
 tb/tb_frame_pixel_server.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_server.sv
// frame_pixel_server: captures one raster-order 8-bit greyscale frame into
// on-chip memory and answers (x_addr, y_addr) lookups with a registered
// one-cycle read. Out-of-frame coordinates return BORDER_VAL.
// Optional build macro CLAMP_BORDER_EN: clamp out-of-frame coordinates per
// axis (edge replication) instead of returning BORDER_VAL.
module frame_pixel_server #(
  parameter int         WIDTH      = 64,
  parameter int         HEIGHT     = 48,
  parameter logic [7:0] BORDER_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sof,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_pixel,
  input  logic [8:0] x_addr,
  input  logic [8:0] y_addr,
  output logic [7:0] rd_pixel,
  output logic       rd_valid,
  output logic       frame_ready,
  output logic       wr_overflow
);

  localparam int          DEPTH  = WIDTH * HEIGHT;
  localparam int          AW     = $clog2(DEPTH);
  localparam logic [8:0]  W9     = 9'(WIDTH);
  localparam logic [8:0]  H9     = 9'(HEIGHT);
  localparam logic [8:0]  W_LAST = 9'(WIDTH - 1);
  localparam logic [8:0]  H_LAST = 9'(HEIGHT - 1);
  localparam logic [17:0] W18    = 18'(WIDTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] wr_x_q, wr_x_d;
  logic [8:0] wr_y_q, wr_y_d;
  logic       wr_ready_q, wr_ready_d;
  logic       frame_ready_q, frame_ready_d;
  logic       wr_overflow_q, wr_overflow_d;
  logic [7:0] rd_pixel_q, rd_pixel_d;
  logic       rd_valid_q;

  logic          wr_en_s;
  logic [8:0]    base_x_s, base_y_s;
  logic [AW-1:0] wr_idx_s, rd_idx_s;
  logic [8:0]    rd_x_s, rd_y_s;
  logic          rd_in_range_s;

  logic [7:0] mem [0:DEPTH-1];

  // Linear memory index y*WIDTH+x; callers only pass in-frame coordinates.
  function automatic logic [AW-1:0] lin_idx(input logic [8:0] x, input logic [8:0] y);
    return AW'(({9'd0, y} * W18) + {9'd0, x});
  endfunction

  // Capture FSM: sof restarts at (0,0) in any state, accepted pixels advance the raster counters.
  always_comb begin
    state_d       = state_q;
    wr_x_d        = wr_x_q;
    wr_y_d        = wr_y_q;
    wr_overflow_d = wr_overflow_q;
    wr_en_s       = 1'b0;
    base_x_s      = wr_x_q;
    base_y_s      = wr_y_q;
    if (sof) begin
      // sof overrides the FULL lock so a same-cycle pixel lands at (0,0)
      base_x_s      = 9'd0;
      base_y_s      = 9'd0;
      wr_en_s       = wr_valid;
      wr_overflow_d = 1'b0;
      state_d       = ST_FILL;
    end else begin
      wr_en_s = wr_valid & wr_ready_q;
      if (wr_valid && !wr_ready_q) begin
        wr_overflow_d = 1'b1;
      end else begin
        wr_overflow_d = wr_overflow_q;
      end
    end
    if (wr_en_s) begin
      if (base_x_s == W_LAST) begin
        wr_x_d = 9'd0;
        if (base_y_s == H_LAST) begin
          wr_y_d  = 9'd0;
          state_d = ST_FULL;
        end else begin
          wr_y_d  = base_y_s + 9'd1;
          state_d = ST_FILL;
        end
      end else begin
        wr_x_d  = base_x_s + 9'd1;
        wr_y_d  = base_y_s;
        state_d = ST_FILL;
      end
    end else begin
      wr_x_d = base_x_s;
      wr_y_d = base_y_s;
    end
    wr_ready_d    = (state_d != ST_FULL);
    frame_ready_d = (state_d == ST_FULL);
    wr_idx_s      = lin_idx(base_x_s, base_y_s);
  end

  // Read address decode: range check (or per-axis clamp) ahead of the memory lookup.
  always_comb begin
`ifdef CLAMP_BORDER_EN
    if (x_addr < W9) begin
      rd_x_s = x_addr;
    end else begin
      rd_x_s = x_addr[8] ? 9'd0 : W_LAST;
    end
    if (y_addr < H9) begin
      rd_y_s = y_addr;
    end else begin
      rd_y_s = y_addr[8] ? 9'd0 : H_LAST;
    end
    rd_in_range_s = 1'b1;
`else
    rd_x_s        = x_addr;
    rd_y_s        = y_addr;
    rd_in_range_s = (x_addr < W9) && (y_addr < H9);
`endif
    // gate the index so an out-of-frame product never reaches the array
    rd_idx_s   = rd_in_range_s ? lin_idx(rd_x_s, rd_y_s) : {AW{1'b0}};
    rd_pixel_d = rd_in_range_s ? mem[rd_idx_s] : BORDER_VAL;
  end

  // Frame memory write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_idx_s] <= wr_pixel;
    end
  end

  // State, counters and registered outputs; read data sees pre-write memory (read-first).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_EMPTY;
      wr_x_q        <= 9'd0;
      wr_y_q        <= 9'd0;
      wr_ready_q    <= 1'b1;
      frame_ready_q <= 1'b0;
      wr_overflow_q <= 1'b0;
      rd_pixel_q    <= 8'h00;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_x_q        <= wr_x_d;
      wr_y_q        <= wr_y_d;
      wr_ready_q    <= wr_ready_d;
      frame_ready_q <= frame_ready_d;
      wr_overflow_q <= wr_overflow_d;
      rd_pixel_q    <= rd_pixel_d;
      rd_valid_q    <= frame_ready_q;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign frame_ready = frame_ready_q;
  assign wr_overflow = wr_overflow_q;
  assign rd_pixel    = rd_pixel_q;
  assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_frame_pixel_server.sv
// Randomized scoreboard bench for frame_pixel_server with a frame-level reference model.
module tb_frame_pixel_server;

  localparam int W = 64;
  localparam int H = 48;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       sof;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_pixel;
  logic [8:0] x_addr;
  logic [8:0] y_addr;
  logic [7:0] rd_pixel;
  logic       rd_valid;
  logic       frame_ready;
  logic       wr_overflow;

  int n_vec = 0;
  int n_err = 0;

  // reference model: the frame as a flat array filled in arrival order
  logic [7:0] model_mem [0:N-1];
  int         model_cnt  = 0;
  bit         model_full = 1'b0;

  logic [7:0] exp_q [$];
  logic [7:0] mon_e;

  frame_pixel_server dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sof        (sof),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_pixel   (wr_pixel),
    .x_addr     (x_addr),
    .y_addr     (y_addr),
    .rd_pixel   (rd_pixel),
    .rd_valid   (rd_valid),
    .frame_ready(frame_ready),
    .wr_overflow(wr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_pix(input int x, input int y);
    int cx;
    int cy;
`ifdef CLAMP_BORDER_EN
    cx = (x < W) ? x : ((x >= 256) ? 0 : W - 1);
    cy = (y < H) ? y : ((y >= 256) ? 0 : H - 1);
    return model_mem[cy * W + cx];
`else
    cx = x;
    cy = y;
    if (cx < W && cy < H) return model_mem[cy * W + cx];
    else return 8'h00;
`endif
  endfunction

  task automatic model_accept(input logic [7:0] p);
    model_mem[model_cnt] = p;
    model_cnt++;
    if (model_cnt == N) begin
      model_full = 1'b1;
      model_cnt  = 0;
    end
  endtask

  task automatic check_reset_vals();
    check("rst_rd_pixel", rd_pixel, 8'h00);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_frame_ready", frame_ready, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_wr_overflow", wr_overflow, 1'b0);
  endtask

  // stream pixels until the model says the frame is complete (or stop_after accepts)
  task automatic fill_frame(input int gap_pct, input bit rnd_pix, input int stop_after);
    int  acc = 0;
    bit  have_prev = 1'b0;
    bit  prev_fr = 1'b0;
    bit  v;
    for (int budget = 0; budget < 20000; budget++) begin
      @(negedge clk);
      sof = 1'b0;
      check("frame_ready", frame_ready, model_full);
      check("wr_ready", wr_ready, !model_full);
      if (have_prev) check("rd_valid_fill", rd_valid, prev_fr);
      prev_fr   = model_full;
      have_prev = 1'b1;
      if (model_full || (stop_after > 0 && acc >= stop_after)) begin
        wr_valid = 1'b0;
        return;
      end
      v        = ($urandom_range(99) >= gap_pct);
      wr_valid = v;
      wr_pixel = rnd_pix ? 8'($urandom) : 8'((model_cnt % W) + (model_cnt / W));
      if (v) begin
        model_accept(wr_pixel);
        acc++;
      end
    end
    wr_valid = 1'b0;
    n_vec++;
    n_err++;
    $display("FAIL fill_timeout: got %0d accepts expected frame completion", acc);
  endtask

  task automatic rd(input int x, input int y);
    @(negedge clk);
    sof      = 1'b0;
    wr_valid = 1'b0;
    x_addr   = 9'(x);
    y_addr   = 9'(y);
    exp_q.push_back(ref_pix(x, y));
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    check("sb_drain", exp_q.size(), 0);
  endtask

  task automatic rand_reads(input int n);
    int x;
    int y;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0)
        x = ($urandom_range(1) == 1) ? $urandom_range(W, 255) : $urandom_range(256, 511);
      else
        x = $urandom_range(0, W - 1);
      if ($urandom_range(3) == 0)
        y = ($urandom_range(1) == 1) ? $urandom_range(H, 255) : $urandom_range(256, 511);
      else
        y = $urandom_range(0, H - 1);
      rd(x, y);
    end
    drain();
  endtask

  task automatic pulse_sof(input bit v, input logic [7:0] p);
    @(negedge clk);
    sof        = 1'b1;
    wr_valid   = v;
    wr_pixel   = p;
    model_full = 1'b0;
    model_cnt  = 0;
    if (v) model_accept(p);
  endtask

  // monitor: each queued expectation corresponds to the address presented before this edge
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("rd_valid_sb", rd_valid, 1'b1);
      check("rd_pixel", rd_pixel, mon_e);
    end
  end

  initial begin
    n_rst    = 1'b0;
    sof      = 1'b0;
    wr_valid = 1'b0;
    wr_pixel = 8'h00;
    x_addr   = 9'd0;
    y_addr   = 9'd0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    n_rst = 1'b1;

    // 1: full frame of (x+y), no gaps
    fill_frame(0, 1'b0, 0);

    // 2/3: directed reads incl. edges and out-of-frame coordinates
    rd(5, 7);
    rd(63, 47);
    rd(9'h1FE, 3);
    rd(70, 3);
    rd(0, 0);
    rd(63, 0);
    rd(0, 47);
    rd(64, 48);
    drain();
    rand_reads(60);

    // 4: overflow in FULL leaves memory untouched
    @(negedge clk);
    wr_valid = 1'b1;
    wr_pixel = 8'h55;
    @(negedge clk);
    wr_valid = 1'b0;
    check("ovf_set", wr_overflow, 1'b1);
    check("ovf_frame_ready", frame_ready, 1'b1);
    @(negedge clk);
    check("ovf_sticky", wr_overflow, 1'b1);
    rd(0, 0);
    rd(1, 0);
    drain();
    pulse_sof(1'b1, 8'hAA);
    @(negedge clk);
    sof      = 1'b0;
    wr_valid = 1'b0;
    check("sof_ovf_clr", wr_overflow, 1'b0);
    check("sof_frame_ready", frame_ready, 1'b0);
    check("sof_wr_ready", wr_ready, 1'b1);
    fill_frame(0, 1'b1, 0);
    rd(0, 0);
    rd(1, 0);
    drain();

    // 5: reset mid-fill, then a complete refill
    pulse_sof(1'b0, 8'h00);
    fill_frame(0, 1'b1, 1000);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
    n_rst      = 1'b1;
    model_cnt  = 0;
    model_full = 1'b0;
    fill_frame(0, 1'b1, 0);
    rand_reads(60);

    // 6: 50% gaps during fill, random pixels
    pulse_sof(1'b0, 8'h00);
    fill_frame(50, 1'b1, 0);
    rand_reads(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
